// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Drives PC / IF-ID / ID-EX enables and flushes from load-use hazards,
// EX-stage redirects and data-memory back-pressure, and keeps saturating
// counts of stall cycles and accepted redirects.
module hazard_ctrl #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [6:0]        opcode_id,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_load_inst,
    input  logic              modify_pc_ex,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              load_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MAX_CYC = (LOAD_USE_CYCLES > FLUSH_CYCLES) ? LOAD_USE_CYCLES : FLUSH_CYCLES;
    localparam int RW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   rem, rem_nxt;
    logic            rs1_used, rs2_used, hazard;
    logic            stall_inc, flush_inc;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // Which source registers the ID instruction actually reads; rs2 of an
    // I-type is immediate bits and must never create a hazard.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode_id)
            7'b0110011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b0100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b0010011: rs1_used = 1'b1;
            7'b0000011: rs1_used = 1'b1;
            7'b1100111: rs1_used = 1'b1;
            default: ;
        endcase
    end

    // Load in EX writing a register the ID instruction reads (x0 excluded).
    assign hazard = ex_load_inst && (ex_rd != '0) &&
                    ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

    // Next-state and output decode; the first matching condition wins.
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        load_stall  = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
            rem_nxt     = '0;
        end else if (mem_busy) begin
            // Full freeze; a redirect seen now re-presents once EX moves again.
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else if (modify_pc_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                rem_nxt   = RW'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end
        end else if (state == FLUSH) begin
            // Keep squashing the wrong-path fetches still coming out of IMEM.
            if_id_flush = 1'b1;
            rem_nxt     = rem - RW'(1);
            if (rem == RW'(1)) state_nxt = RUN;
        end else if (state == LSTALL) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            load_stall  = 1'b1;
            stall_inc   = 1'b1;
            rem_nxt     = rem - RW'(1);
            if (rem == RW'(1)) state_nxt = RUN;
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            load_stall  = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                state_nxt = LSTALL;
                rem_nxt   = RW'(LOAD_USE_CYCLES - 1);
            end
        end
    end

    // State, remaining-cycle counter and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            rem       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances with different parameter
// sets; directed cycles push hand-computed expectations, a negedge monitor
// pops and compares them.
module tb_hazard_ctrl;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, load_stall}
    localparam logic [5:0] O_RUN = 6'b111000;
    localparam logic [5:0] O_STL = 6'b001011;
    localparam logic [5:0] O_RED = 6'b111110;
    localparam logic [5:0] O_FLS = 6'b111100;
    localparam logic [5:0] O_BSY = 6'b000000;
    localparam logic [5:0] O_RST = 6'b000110;

    typedef struct {
        logic [5:0] o;
        int         sc;
        int         fc;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LOAD_USE_CYCLES=1, FLUSH_CYCLES=1, CNT_W=16
    logic        a_rst = 1'b0, a_ld = 1'b0, a_mp = 1'b0, a_mb = 1'b0;
    logic [4:0]  a_rs1 = '0, a_rs2 = '0, a_rd = '0;
    logic [6:0]  a_op = '0;
    logic        a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_flush, a_load_stall;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic [5:0]  a_o;

    // Instance B: LOAD_USE_CYCLES=3, FLUSH_CYCLES=2, CNT_W=2
    logic        b_rst = 1'b0, b_ld = 1'b0, b_mp = 1'b0, b_mb = 1'b0;
    logic [4:0]  b_rs1 = '0, b_rs2 = '0, b_rd = '0;
    logic [6:0]  b_op = '0;
    logic        b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_flush, b_load_stall;
    logic [1:0]  b_stall_cnt, b_flush_cnt;
    logic [5:0]  b_o;

    assign a_o = {a_pc_en, a_if_id_en, a_id_ex_en, a_if_id_flush, a_id_ex_flush, a_load_stall};
    assign b_o = {b_pc_en, b_if_id_en, b_id_ex_en, b_if_id_flush, b_id_ex_flush, b_load_stall};

    hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(a_rst), .id_rs1(a_rs1), .id_rs2(a_rs2), .opcode_id(a_op),
        .ex_rd(a_rd), .ex_load_inst(a_ld), .modify_pc_ex(a_mp), .mem_busy(a_mb),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush),
        .id_ex_en(a_id_ex_en), .id_ex_flush(a_id_ex_flush), .load_stall(a_load_stall),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(b_rst), .id_rs1(b_rs1), .id_rs2(b_rs2), .opcode_id(b_op),
        .ex_rd(b_rd), .ex_load_inst(b_ld), .modify_pc_ex(b_mp), .mem_busy(b_mb),
        .pc_en(b_pc_en), .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush),
        .id_ex_en(b_id_ex_en), .id_ex_flush(b_id_ex_flush), .load_stall(b_load_stall),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad   = 0;
    logic done  = 1'b0;

    // One cycle of stimulus on instance inst (0=A, 1=B) plus its expectation.
    task automatic cyc(input int inst, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] op, input logic [4:0] rd, input logic ld, input logic mp,
                       input logic mb, input logic [5:0] eo, input int es, input int ef,
                       input string nm);
        exp_t e;
        e.o = eo; e.sc = es; e.fc = ef; e.nm = nm;
        if (inst == 0) begin
            a_rst = r; a_rs1 = rs1; a_rs2 = rs2; a_op = op; a_rd = rd; a_ld = ld; a_mp = mp; a_mb = mb;
            qa.push_back(e);
        end else begin
            b_rst = r; b_rs1 = rs1; b_rs2 = rs2; b_op = op; b_rd = rd; b_ld = ld; b_mp = mp; b_mb = mb;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int inst, input logic [5:0] eo, input int es, input int ef, input string nm);
        cyc(inst, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, eo, es, ef, nm);
    endtask

    // Monitor: compare whatever expectation is pending, mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            total = total + 1;
            if (a_o !== ea.o || (ea.sc >= 0 && (int'(a_stall_cnt) != ea.sc || int'(a_flush_cnt) != ea.fc))) begin
                bad = bad + 1;
                $display("FAIL %s: got outs=%b stall_cnt=%0d flush_cnt=%0d, want outs=%b stall_cnt=%0d flush_cnt=%0d",
                         ea.nm, a_o, a_stall_cnt, a_flush_cnt, ea.o, ea.sc, ea.fc);
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            total = total + 1;
            if (b_o !== eb.o || (eb.sc >= 0 && (int'(b_stall_cnt) != eb.sc || int'(b_flush_cnt) != eb.fc))) begin
                bad = bad + 1;
                $display("FAIL %s: got outs=%b stall_cnt=%0d flush_cnt=%0d, want outs=%b stall_cnt=%0d flush_cnt=%0d",
                         eb.nm, b_o, b_stall_cnt, b_flush_cnt, eb.o, eb.sc, eb.fc);
            end
        end
        if (done) begin
            total = total + 1;
            if (qa.size() != 0 || qb.size() != 0) begin
                bad = bad + 1;
                $display("FAIL drain: got pending=%0d, want pending=0", qa.size() + qb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // ---------------- instance A ----------------
        cyc(0, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, -1, -1, "a_rst0");
        cyc(0, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 0, 0, "a_rst1");
        idle(0, O_RUN, 0, 0, "a_idle");
        cyc(0, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 0, 0, "a_lu_rs1");
        cyc(0, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN, 1, 0, "a_lu_done");
        cyc(0, 1'b0, 5'd0, 5'd1, OP_R, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN, 1, 0, "a_x0");
        cyc(0, 1'b0, 5'd1, 5'd5, OP_I, 5'd5, 1'b1, 1'b0, 1'b0, O_RUN, 1, 0, "a_itype_rs2");
        cyc(0, 1'b0, 5'd1, 5'd5, OP_S, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 1, 0, "a_sw_rs2");
        cyc(0, 1'b0, 5'd1, 5'd5, OP_S, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN, 2, 0, "a_sw_done");
        cyc(0, 1'b0, 5'd7, 5'd2, OP_L, 5'd7, 1'b1, 1'b0, 1'b0, O_STL, 2, 0, "a_ld_rs1");
        cyc(0, 1'b0, 5'd1, 5'd9, OP_B, 5'd9, 1'b1, 1'b0, 1'b0, O_STL, 3, 0, "a_br_rs2");
        idle(0, O_RUN, 4, 0, "a_stalls_done");
        cyc(0, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 4, 0, "a_redirect");
        idle(0, O_RUN, 4, 1, "a_after_redir");
        cyc(0, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_BSY, 4, 1, "a_busy0");
        cyc(0, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_BSY, 4, 1, "a_busy1");
        cyc(0, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 4, 1, "a_busy_release");
        idle(0, O_RUN, 4, 2, "a_after_busy");
        cyc(0, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b1, 1'b0, O_RED, 4, 2, "a_redir_over_hazard");
        idle(0, O_RUN, 4, 3, "a_after_redir_hz");
        cyc(0, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b1, O_BSY, 4, 3, "a_busy_over_hazard");
        cyc(0, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 4, 3, "a_hazard_after_busy");
        idle(0, O_RUN, 5, 3, "a_end");
        // ---------------- instance B ----------------
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, -1, -1, "b_rst0");
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 0, 0, "b_rst1");
        idle(1, O_RUN, 0, 0, "b_idle");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 0, 0, "b_lu0");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 1, 0, "b_lu1");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 2, 0, "b_lu2");
        idle(1, O_RUN, 3, 0, "b_lu_end");
        cyc(1, 1'b0, 5'd0, 5'd1, OP_R, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN, 3, 0, "b_x0");
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 3, 0, "b_rst_a");
        idle(1, O_RUN, 0, 0, "b_cleared");
        cyc(1, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 0, 0, "b_redir");
        idle(1, O_FLS, 0, 1, "b_flush1");
        idle(1, O_RUN, 0, 1, "b_flush_end");
        cyc(1, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 0, 1, "b_redir2");
        cyc(1, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 0, 2, "b_redir_restart");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_FLS, 0, 3, "b_flush_ignores_hz");
        idle(1, O_RUN, 0, 3, "b_flush_end2");
        cyc(1, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 0, 3, "b_redir_sat");
        idle(1, O_FLS, 0, 3, "b_fcnt_sat");
        idle(1, O_RUN, 0, 3, "b_flush_end3");
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 0, 3, "b_rst_b");
        idle(1, O_RUN, 0, 0, "b_cleared2");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 0, 0, "b_ls_start");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b1, 1'b0, O_RED, 1, 0, "b_ls_redir");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_FLS, 1, 1, "b_ls_flush");
        idle(1, O_RUN, 1, 1, "b_ls_aborted");
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 1, 1, "b_rst_c");
        idle(1, O_RUN, 0, 0, "b_cleared3");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 0, 0, "b_busy_ls_start");
        for (int i = 0; i < 4; i++)
            cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b1, 1'b1, O_BSY, 1, 0, "b_busy_freeze");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b1, 1'b0, O_RED, 1, 0, "b_busy_release");
        idle(1, O_FLS, 1, 1, "b_busy_flush");
        idle(1, O_RUN, 1, 1, "b_busy_end");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 1, 1, "b_mid_stall");
        cyc(1, 1'b1, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_RST, 2, 1, "b_rst_mid_stall");
        idle(1, O_RUN, 0, 0, "b_after_rst_stall");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 0, 0, "b_sat0");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 1, 0, "b_sat1");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 2, 0, "b_sat2");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, O_STL, 3, 0, "b_sat3");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 3, 0, "b_sat4");
        cyc(1, 1'b0, 5'd5, 5'd1, OP_R, 5'd5, 1'b0, 1'b0, 1'b0, O_STL, 3, 0, "b_sat5");
        idle(1, O_RUN, 3, 0, "b_scnt_sat");
        cyc(1, 1'b0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_RED, 3, 0, "b_redir_pre_rst");
        cyc(1, 1'b1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, 3, 1, "b_rst_mid_flush");
        idle(1, O_RUN, 0, 0, "b_after_rst_flush");
        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL summary: got no end of run, want monitor to finish");
        $fatal(1, "bench did not terminate");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32 core; replaces the single-cycle branch-flush hazard logic.
- Adds load-use stall detection with configurable load-to-use latency.
- Adds multi-cycle front-end flush after an EX-stage redirect, for synchronous instruction memories.
- Adds a global data-memory freeze and saturating performance counters. Sits beside the IF/ID and ID/EX pipeline registers and drives their enables and flushes.

Parameters:
- REG_AW, 5, register-address width of rs1/rs2/rd.
- LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard; must be ≥1.
- FLUSH_CYCLES, 1, cycles if_id_flush stays high after a redirect; must be ≥1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, synchronous active-high reset.
- id_rs1, input, REG_AW, rs1 field of the instruction in ID.
- id_rs2, input, REG_AW, rs2 field of the instruction in ID.
- opcode_id, input, 7, opcode of the instruction in ID.
- ex_rd, input, REG_AW, rd of the instruction in EX.
- ex_load_inst, input, 1, instruction in EX is a load.
- modify_pc_ex, input, 1, EX resolved a redirect (mispredict or taken jump/branch).
- mem_busy, input, 1, data memory not ready; the whole pipeline must freeze.
- pc_en, output, 1, PC register enable.
- if_id_en, output, 1, IF/ID enable.
- if_id_flush, output, 1, IF/ID clear to NOP.
- id_ex_en, output, 1, ID/EX enable.
- id_ex_flush, output, 1, ID/EX clear to bubble.
- load_stall, output, 1, a load-use stall is active this cycle.
- stall_cnt, output, CNT_W, count of load_stall cycles.
- flush_cnt, output, CNT_W, count of accepted redirects.

Behaviour:
- Source-usage decode:
  - rs1_used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2_used for opcodes 0110011, 0100011, 1100011.
- Hazard condition: hazard = ex_load_inst & (ex_rd≠0) & ((rs1_used & ex_rd==id_rs1) | (rs2_used & ex_rd==id_rs2)).
- Registered state: state ∈ {RUN, LSTALL, FLUSH}; rem counter of width clog2(max(LOAD_USE_CYCLES,FLUSH_CYCLES))+1.
- Outputs are combinational from state, rem and inputs. Each cycle takes the first matching case below.
  1. rst=1:
     - Outputs: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, load_stall=0.
     - Next cycle: state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
  2. mem_busy=1:
     - Outputs: all enables 0, all flushes 0, load_stall=0.
     - state, rem and counters hold. A coincident modify_pc_ex is NOT accepted; EX is frozen, so it re-presents next cycle.
  3. modify_pc_ex=1 (any state):
     - Outputs: pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1, load_stall=0.
     - flush_cnt++.
     - If FLUSH_CYCLES>1: state←FLUSH, rem←FLUSH_CYCLES-1. Else state←RUN.
     - Aborts any LSTALL in progress and restarts any FLUSH.
  4. state=FLUSH:
     - Outputs: pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=0.
     - hazard is ignored.
     - rem--; on rem==1, state←RUN.
  5. state=LSTALL:
     - Outputs: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, if_id_flush=0, load_stall=1.
     - stall_cnt++; rem--; on rem==1, state←RUN.
     - ex_rd/hazard are not re-evaluated.
  6. state=RUN and hazard:
     - Same outputs as LSTALL; stall_cnt++.
     - If LOAD_USE_CYCLES>1: state←LSTALL, rem←LOAD_USE_CYCLES-1.
  7. Otherwise:
     - Outputs: all enables 1, flushes 0, load_stall=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- x0 never triggers a hazard.
- A hazard on rs2 for an I-type (rs2 field garbage) must not stall.
- Reset mid-stall or mid-flush returns to RUN next cycle with all counters cleared.

Test Plan:
- LOAD_USE_CYCLES=1: lw x5 in EX (ex_rd=5, ex_load_inst=1), ID add x6,x5,x1 (0110011, rs1=5) -> exactly 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1, load_stall=1; stall_cnt=1.
- LOAD_USE_CYCLES=3, same hazard -> load_stall high 3 consecutive cycles, then RUN; stall_cnt=3. Repeat with ex_rd=0 -> no stall.
- I-type addi (0010011) with id_rs2=5, ex_rd=5 load -> no stall. sw (0100011) rs2=5 -> stall.
- FLUSH_CYCLES=2, modify_pc_ex 1 cycle -> if_id_flush high 2 cycles, id_ex_flush high first cycle only; flush_cnt=1. Second redirect in the FLUSH cycle -> flush window restarts.
- Redirect during LSTALL (LOAD_USE_CYCLES=3, redirect on 2nd stall cycle) -> stall aborted, flush outputs that cycle; stall_cnt=1.
- mem_busy=1 for 4 cycles during LSTALL with modify_pc_ex=1 -> all enables 0, counters/rem frozen; on release the redirect is accepted and flush_cnt increments once. CNT_W=2: 5 stall cycles -> stall_cnt=3.
